// File: rtl/axi_addr_issue_pkg.sv
// -----------------------------------------------------------------------------
// axi_issue_pkg
// Purpose : Shared definitions for the AXI address-channel issuer.
//           - descriptor field widths and offsets ({id,size,len,addr} packing)
//           - FSM state encoding
//           - 4 KB page constants used by the optional burst splitter
// Ports   : none (package)
// Build   : no configuration macros are read here.
// -----------------------------------------------------------------------------
package axi_issue_pkg;

    localparam int SIZE_W     = 3;
    localparam int PAGE_BYTES = 4096;
    localparam int PAGE_OFF_W = 12;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    // Descriptor layout, LSB first: addr, len, size, id.
    function automatic int desc_len_lsb(input int addr_w);
        return addr_w;
    endfunction

    function automatic int desc_size_lsb(input int addr_w, input int len_w);
        return addr_w + len_w;
    endfunction

    function automatic int desc_id_lsb(input int addr_w, input int len_w);
        return addr_w + len_w + SIZE_W;
    endfunction

endpackage

// File: rtl/axi_addr_issue_if.sv
// -----------------------------------------------------------------------------
// axi_addr_issue_if
// Purpose : AXI AR/AW address channel bundle.
// Signals : axi_aid, axi_addr, axi_alen, axi_asize, axi_axvalid (master -> slave)
//           axi_axready (slave -> master)
// Modports: master (issuer side), slave (interconnect side)
// -----------------------------------------------------------------------------
interface axi_addr_issue_if
    import axi_issue_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int ID_W   = 6,
    parameter int LEN_W  = 8
) ();

    logic [ID_W-1:0]   axi_aid;
    logic [ADDR_W-1:0] axi_addr;
    logic [LEN_W-1:0]  axi_alen;
    logic [SIZE_W-1:0] axi_asize;
    logic              axi_axvalid;
    logic              axi_axready;

    modport master (
        output axi_aid, axi_addr, axi_alen, axi_asize, axi_axvalid,
        input  axi_axready
    );

    modport slave (
        input  axi_aid, axi_addr, axi_alen, axi_asize, axi_axvalid,
        output axi_axready
    );

endinterface

// File: rtl/axi_addr_issue_4k_splitter.sv
// -----------------------------------------------------------------------------
// axi_4k_splitter
// Purpose : Combinational next-piece calculator for bursts that must not
//           cross a 4 KB page. Given the start address, beat size and the
//           number of beats still to issue, returns the piece to issue now
//           and where the following piece starts.
// Ports   : i_addr      piece start address
//           i_size      AXI size (bytes per beat = 2^size)
//           i_beats     beats remaining (>= 1), LEN_W+1 bits
//           o_len       AXI len for this piece (beats-1)
//           o_next_addr start of the next page
//           o_rem       beats left after this piece
//           o_last      this piece finishes the descriptor
// Used only when AXI_ADDR_SPLIT_4K_EN is defined.
// -----------------------------------------------------------------------------
module axi_4k_splitter
    import axi_issue_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int LEN_W  = 8
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [SIZE_W-1:0] i_size,
    input  logic [LEN_W:0]    i_beats,
    output logic [LEN_W-1:0]  o_len,
    output logic [ADDR_W-1:0] o_next_addr,
    output logic [LEN_W:0]    o_rem,
    output logic              o_last
);

    // Wide enough for 4096 plus the rounding term, and for any beat count.
    localparam int CW     = (LEN_W + 1 > PAGE_OFF_W + 2) ? LEN_W + 1 : PAGE_OFF_W + 2;
    localparam int PAGE_W = ADDR_W - PAGE_OFF_W;

    logic [CW-1:0]     w_room;
    logic [CW-1:0]     w_round;
    logic [CW-1:0]     w_btb;
    logic [CW-1:0]     w_beats;
    logic [PAGE_W-1:0] w_page_next;

    always_comb begin
        // Bytes left in the page (1..4096), converted to beats rounding up.
        w_room      = CW'(PAGE_BYTES) - CW'(i_addr[PAGE_OFF_W-1:0]);
        w_round     = (CW'(1) << i_size) - CW'(1);
        w_btb       = (w_room + w_round) >> i_size;
        w_beats     = CW'(i_beats);
        w_page_next = i_addr[ADDR_W-1:PAGE_OFF_W] + PAGE_W'(1);
        o_next_addr = {w_page_next, PAGE_OFF_W'(0)};
        if (w_beats <= w_btb) begin
            o_last = 1'b1;
            o_len  = LEN_W'(w_beats - CW'(1));
            o_rem  = '0;
        end else begin
            // btb < beats <= 2^LEN_W, so btb-1 always fits in LEN_W bits.
            o_last = 1'b0;
            o_len  = LEN_W'(w_btb - CW'(1));
            o_rem  = (LEN_W+1)'(w_beats - w_btb);
        end
    end

endmodule

// File: rtl/axi_addr_issue.sv
// -----------------------------------------------------------------------------
// axi_addr_issue
// Purpose : Pops transaction descriptors from a show-ahead FIFO and drives an
//           AXI AR/AW address channel from registers. Limits the number of
//           outstanding transactions and logs each accepted address beat into
//           the tracking FIFO so the response side can match IDs.
// Ports   : clk, reset                synchronous active-high reset
//           addrtrans_mem_rddata      head descriptor {id,size,len,addr}
//           addrtrans_fifo_empty      descriptor FIFO empty
//           addrtrans_mem_rd          pop strobe (one cycle per descriptor)
//           axi                       address channel (master modport)
//           cpl_done                  one pulse per completed transaction
//           rd_transfifo_wr           tracking-FIFO write strobe (= fire)
//           io_transfifo_wrdata       {last_piece,id,size,len,addr}
//           ot_cnt                    outstanding transaction count
//           err_cpl_underflow         sticky: completion seen with ot_cnt==0
// Build   : define AXI_ADDR_SPLIT_4K_EN to split bursts at 4 KB boundaries;
//           otherwise each descriptor is issued unchanged as one piece.
// -----------------------------------------------------------------------------
module axi_addr_issue
    import axi_issue_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int ID_W   = 6,
    parameter int LEN_W  = 8,
    parameter int OT_MAX = 8,
    parameter int DESC_W = ID_W + 3 + LEN_W + ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DESC_W-1:0] addrtrans_mem_rddata,
    input  logic              addrtrans_fifo_empty,
    output logic              addrtrans_mem_rd,
    axi_addr_issue_if.master  axi,
    input  logic              cpl_done,
    output logic              rd_transfifo_wr,
    output logic [DESC_W:0]   io_transfifo_wrdata,
    output logic [7:0]        ot_cnt,
    output logic              err_cpl_underflow
);

    localparam int        LEN_LSB  = desc_len_lsb(ADDR_W);
    localparam int        SIZE_LSB = desc_size_lsb(ADDR_W, LEN_W);
    localparam int        ID_LSB   = desc_id_lsb(ADDR_W, LEN_W);
    localparam logic [7:0] OT_LIMIT = 8'(OT_MAX);

    // Registered state
    state_t            r_state;
    logic              r_valid;
    logic [ID_W-1:0]   r_id;
    logic [SIZE_W-1:0] r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic              r_last;
    logic [7:0]        r_ot_cnt;
    logic              r_err;

    // Descriptor fields at the FIFO head
    logic [ADDR_W-1:0] w_desc_addr;
    logic [LEN_W-1:0]  w_desc_len;
    logic [SIZE_W-1:0] w_desc_size;
    logic [ID_W-1:0]   w_desc_id;

    // Piece to issue when loading or advancing
    logic [ADDR_W-1:0] w_pc_addr;
    logic [LEN_W-1:0]  w_pc_len;
    logic              w_pc_last;

    // Control
    logic              w_fire;
    logic              w_cpl_ok;
    logic [7:0]        w_ot_next;
    logic              w_slot_free;
    logic              w_may_load;
    logic              w_load;
    logic              w_advance;
    logic              w_valid_next;
    state_t            w_state_next;

    assign w_desc_addr = addrtrans_mem_rddata[ADDR_W-1:0];
    assign w_desc_len  = addrtrans_mem_rddata[LEN_LSB +: LEN_W];
    assign w_desc_size = addrtrans_mem_rddata[SIZE_LSB +: SIZE_W];
    assign w_desc_id   = addrtrans_mem_rddata[ID_LSB +: ID_W];

`ifdef AXI_ADDR_SPLIT_4K_EN
    // Continuation of a split descriptor: where the next piece starts and
    // how many beats are still owed.
    logic [ADDR_W-1:0] r_next_addr;
    logic [LEN_W:0]    r_rem;
    logic [LEN_W:0]    w_desc_beats;
    logic [SIZE_W-1:0] w_src_size;
    logic [LEN_W:0]    w_src_beats;
    logic [ADDR_W-1:0] w_pc_next_addr;
    logic [LEN_W:0]    w_pc_rem;

    assign w_desc_beats = {1'b0, w_desc_len} + (LEN_W+1)'(1);
    assign w_pc_addr    = w_load ? w_desc_addr  : r_next_addr;
    assign w_src_size   = w_load ? w_desc_size  : r_size;
    assign w_src_beats  = w_load ? w_desc_beats : r_rem;

    axi_4k_splitter #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_splitter (
        .i_addr      (w_pc_addr),
        .i_size      (w_src_size),
        .i_beats     (w_src_beats),
        .o_len       (w_pc_len),
        .o_next_addr (w_pc_next_addr),
        .o_rem       (w_pc_rem),
        .o_last      (w_pc_last)
    );
`else
    assign w_pc_addr = w_desc_addr;
    assign w_pc_len  = w_desc_len;
    assign w_pc_last = 1'b1;
`endif

    // Reset gates every strobe so an abandoned piece neither pops nor logs.
    assign w_fire      = r_valid & axi.axi_axready & ~reset;
    assign w_cpl_ok    = cpl_done & (r_ot_cnt != 8'd0) & ~reset;
    assign w_slot_free = (w_ot_next < OT_LIMIT);
    assign w_may_load  = ~addrtrans_fifo_empty & w_slot_free;

    always_comb begin
        w_ot_next = r_ot_cnt;
        case ({w_fire, w_cpl_ok})
            2'b10:   w_ot_next = r_ot_cnt + 8'd1;
            2'b01:   w_ot_next = r_ot_cnt - 8'd1;
            default: w_ot_next = r_ot_cnt;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_valid_next = r_valid;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_may_load) begin
                    w_load       = 1'b1;
                    w_valid_next = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (r_valid) begin
                    if (w_fire) begin
                        if (!r_last) begin
                            // More pieces: keep going if a slot is left,
                            // otherwise park with valid low.
                            if (w_slot_free) begin
                                w_advance = 1'b1;
                            end else begin
                                w_valid_next = 1'b0;
                            end
                        end else if (w_may_load) begin
                            // Back-to-back: new descriptor, valid stays high.
                            w_load = 1'b1;
                        end else begin
                            w_valid_next = 1'b0;
                            w_state_next = ST_IDLE;
                        end
                    end
                end else if (w_slot_free) begin
                    // Parked mid-descriptor: resume once a completion frees a slot.
                    w_advance    = 1'b1;
                    w_valid_next = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_valid  <= 1'b0;
            r_id     <= '0;
            r_size   <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_last   <= 1'b0;
            r_ot_cnt <= '0;
            r_err    <= 1'b0;
`ifdef AXI_ADDR_SPLIT_4K_EN
            r_next_addr <= '0;
            r_rem       <= '0;
`endif
        end else begin
            r_state  <= w_state_next;
            r_valid  <= w_valid_next;
            r_ot_cnt <= w_ot_next;
            if (cpl_done && (r_ot_cnt == 8'd0)) begin
                r_err <= 1'b1;
            end
            if (w_load) begin
                r_id   <= w_desc_id;
                r_size <= w_desc_size;
            end
            if (w_load || w_advance) begin
                r_addr <= w_pc_addr;
                r_len  <= w_pc_len;
                r_last <= w_pc_last;
`ifdef AXI_ADDR_SPLIT_4K_EN
                r_next_addr <= w_pc_next_addr;
                r_rem       <= w_pc_rem;
`endif
            end
        end
    end

    assign addrtrans_mem_rd    = w_load & ~reset;
    assign rd_transfifo_wr     = w_fire;
    assign io_transfifo_wrdata = {r_last, r_id, r_size, r_len, r_addr};
    assign ot_cnt              = r_ot_cnt;
    assign err_cpl_underflow   = r_err;

    assign axi.axi_aid     = r_id;
    assign axi.axi_addr    = r_addr;
    assign axi.axi_alen    = r_len;
    assign axi.axi_asize   = r_size;
    assign axi.axi_axvalid = r_valid;

endmodule

// File: tb/tb_axi_addr_issue.sv
// -----------------------------------------------------------------------------
// tb_axi_addr_issue
// Purpose : Directed self-checking bench for axi_addr_issue (default
//           parameters). The 4 KB split case follows AXI_ADDR_SPLIT_4K_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_addr_issue;
    import axi_issue_pkg::*;

    localparam int ADDR_W = 64;
    localparam int ID_W   = 6;
    localparam int LEN_W  = 8;
    localparam int OT_MAX = 8;
    localparam int DESC_W = ID_W + 3 + LEN_W + ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DESC_W-1:0] addrtrans_mem_rddata = '0;
    logic              addrtrans_fifo_empty = 1'b1;
    logic              addrtrans_mem_rd;
    logic              cpl_done = 1'b0;
    logic              rd_transfifo_wr;
    logic [DESC_W:0]   io_transfifo_wrdata;
    logic [7:0]        ot_cnt;
    logic              err_cpl_underflow;

    axi_addr_issue_if #(.ADDR_W(ADDR_W), .ID_W(ID_W), .LEN_W(LEN_W)) axi_bus ();

    axi_addr_issue #(
        .ADDR_W (ADDR_W),
        .ID_W   (ID_W),
        .LEN_W  (LEN_W),
        .OT_MAX (OT_MAX)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .addrtrans_mem_rddata (addrtrans_mem_rddata),
        .addrtrans_fifo_empty (addrtrans_fifo_empty),
        .addrtrans_mem_rd     (addrtrans_mem_rd),
        .axi                  (axi_bus),
        .cpl_done             (cpl_done),
        .rd_transfifo_wr      (rd_transfifo_wr),
        .io_transfifo_wrdata  (io_transfifo_wrdata),
        .ot_cnt               (ot_cnt),
        .err_cpl_underflow    (err_cpl_underflow)
    );

    always #5 clk = ~clk;

    logic [DESC_W-1:0] fifo_q[$];
    int checks  = 0;
    int errors  = 0;
    int pop_cnt = 0;
    int wr_cnt  = 0;

    task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DESC_W:0] exp_wr(input logic last, input logic [5:0] id,
                                               input logic [2:0] sz, input logic [7:0] len,
                                               input logic [63:0] a);
        return {last, id, sz, len, a};
    endfunction

    task automatic refresh_fifo();
        addrtrans_fifo_empty = (fifo_q.size() == 0);
        addrtrans_mem_rddata = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    endtask

    task automatic push(input logic [5:0] id, input logic [2:0] sz, input logic [7:0] len,
                        input logic [63:0] a);
        fifo_q.push_back({id, sz, len, a});
        refresh_fifo();
        #1;
    endtask

    // One clock: strobes are sampled just before the edge, the show-ahead
    // FIFO model pops on the edge, outputs are read 2 ns later.
    task automatic tick();
        logic            pop_now;
        logic            wr_now;
        logic [DESC_W:0] wd;
        pop_now = addrtrans_mem_rd;
        wr_now  = rd_transfifo_wr;
        wd      = io_transfifo_wrdata;
        @(posedge clk);
        if (pop_now && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            pop_cnt++;
        end
        if (wr_now) begin
            wr_cnt++;
            $display("issue: last=%0d id=%0d size=%0d len=%0d addr=0x%0h ot=%0d",
                     wd[DESC_W], wd[DESC_W-1 -: ID_W], wd[DESC_W-1-ID_W -: 3],
                     wd[ADDR_W +: LEN_W], wd[ADDR_W-1:0], ot_cnt);
        end
        #2;
        refresh_fifo();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            cpl_done = 1'b1;
            tick();
        end
        cpl_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int pops0;
        int wrs0;
        axi_bus.axi_axready = 1'b0;
        refresh_fifo();
        // ---------------- reset state ----------------
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b0;
        #1;
        check_value("rst_valid", axi_bus.axi_axvalid, 1'b0);
        check_value("rst_addr", axi_bus.axi_addr, 64'h0);
        check_value("rst_ot", ot_cnt, 8'd0);
        check_value("rst_err", err_cpl_underflow, 1'b0);
        check_value("rst_pop", addrtrans_mem_rd, 1'b0);
        check_value("rst_wr", rd_transfifo_wr, 1'b0);

        // ---------------- 1: single descriptor ----------------
        axi_bus.axi_axready = 1'b1;
        push(6'd5, 3'd3, 8'd7, 64'h1000);
        check_value("t1_pop", addrtrans_mem_rd, 1'b1);
        tick();
        check_value("t1_valid", axi_bus.axi_axvalid, 1'b1);
        check_value("t1_aid", axi_bus.axi_aid, 6'd5);
        check_value("t1_addr", axi_bus.axi_addr, 64'h1000);
        check_value("t1_len", axi_bus.axi_alen, 8'd7);
        check_value("t1_size", axi_bus.axi_asize, 3'd3);
        check_value("t1_wr", rd_transfifo_wr, 1'b1);
        check_value("t1_wrdata", io_transfifo_wrdata, exp_wr(1'b1, 6'd5, 3'd3, 8'd7, 64'h1000));
        tick();
        check_value("t1_valid_drop", axi_bus.axi_axvalid, 1'b0);
        check_value("t1_ot", ot_cnt, 8'd1);
        check_value("t1_pops", pop_cnt, 1);
        drain(1);
        check_value("t1_ot_drained", ot_cnt, 8'd0);

        // ---------------- 2: backpressure holds fields ----------------
        axi_bus.axi_axready = 1'b0;
        push(6'h2A, 3'd2, 8'd3, 64'h2000_0040);
        tick();
        for (int i = 0; i < 5; i++) begin
            check_value("t2_valid", axi_bus.axi_axvalid, 1'b1);
            check_value("t2_fields", {axi_bus.axi_aid, axi_bus.axi_asize, axi_bus.axi_alen, axi_bus.axi_addr},
                        {6'h2A, 3'd2, 8'd3, 64'h2000_0040});
            check_value("t2_no_wr", rd_transfifo_wr, 1'b0);
            tick();
        end
        axi_bus.axi_axready = 1'b1;
        #1;
        check_value("t2_wr", rd_transfifo_wr, 1'b1);
        check_value("t2_wrdata", io_transfifo_wrdata, exp_wr(1'b1, 6'h2A, 3'd2, 8'd3, 64'h2000_0040));
        tick();
        check_value("t2_ot", ot_cnt, 8'd1);
        drain(1);

        // ---------------- 3: four back-to-back ----------------
        for (int i = 0; i < 4; i++) push(6'(i), 3'd2, 8'(i), 64'(32'h3000 + 32'h100 * i));
        for (int i = 0; i < 4; i++) begin
            tick();
            check_value("t3_valid", axi_bus.axi_axvalid, 1'b1);
            check_value("t3_addr", axi_bus.axi_addr, 64'(32'h3000 + 32'h100 * i));
            check_value("t3_wr", rd_transfifo_wr, 1'b1);
        end
        tick();
        check_value("t3_valid_drop", axi_bus.axi_axvalid, 1'b0);
        check_value("t3_ot", ot_cnt, 8'd4);

        // ---------------- 4: outstanding limit ----------------
        for (int i = 0; i < 5; i++) push(6'(10 + i), 3'd1, 8'd0, 64'(32'h4000 + 32'h40 * i));
        for (int i = 0; i < 4; i++) begin
            tick();
            check_value("t4_valid", axi_bus.axi_axvalid, 1'b1);
            check_value("t4_aid", axi_bus.axi_aid, 6'(10 + i));
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            check_value("t4_stall_valid", axi_bus.axi_axvalid, 1'b0);
            check_value("t4_stall_ot", ot_cnt, 8'd8);
            check_value("t4_stall_pop", addrtrans_mem_rd, 1'b0);
        end
        cpl_done = 1'b1;
        #1;
        check_value("t4_pop_on_cpl", addrtrans_mem_rd, 1'b1);
        tick();
        check_value("t4_resume_valid", axi_bus.axi_axvalid, 1'b1);
        check_value("t4_resume_aid", axi_bus.axi_aid, 6'd14);
        check_value("t4_resume_wr", rd_transfifo_wr, 1'b1);
        tick();
        cpl_done = 1'b0;
        check_value("t4_fire_cpl_ot", ot_cnt, 8'd7);
        drain(7);
        check_value("t4_ot_zero", ot_cnt, 8'd0);

        // ---------------- 5: 4 KB boundary ----------------
        pops0 = pop_cnt;
        push(6'd7, 3'd4, 8'd7, 64'h0FC0);
        check_value("t5_pop", addrtrans_mem_rd, 1'b1);
        tick();
`ifdef AXI_ADDR_SPLIT_4K_EN
        check_value("t5_p1_addr", axi_bus.axi_addr, 64'h0FC0);
        check_value("t5_p1_len", axi_bus.axi_alen, 8'd3);
        check_value("t5_p1_wrdata", io_transfifo_wrdata, exp_wr(1'b0, 6'd7, 3'd4, 8'd3, 64'h0FC0));
        tick();
        check_value("t5_p2_valid", axi_bus.axi_axvalid, 1'b1);
        check_value("t5_p2_addr", axi_bus.axi_addr, 64'h1000);
        check_value("t5_p2_wrdata", io_transfifo_wrdata, exp_wr(1'b1, 6'd7, 3'd4, 8'd3, 64'h1000));
        tick();
        check_value("t5_ot", ot_cnt, 8'd2);
        check_value("t5_pops", pop_cnt - pops0, 1);
        drain(2);
`else
        check_value("t5_addr", axi_bus.axi_addr, 64'h0FC0);
        check_value("t5_len", axi_bus.axi_alen, 8'd7);
        check_value("t5_wrdata", io_transfifo_wrdata, exp_wr(1'b1, 6'd7, 3'd4, 8'd7, 64'h0FC0));
        tick();
        check_value("t5_valid_drop", axi_bus.axi_axvalid, 1'b0);
        check_value("t5_ot", ot_cnt, 8'd1);
        check_value("t5_pops", pop_cnt - pops0, 1);
        drain(1);
`endif

        // ---------------- 6: underflow and reset mid-burst ----------------
        check_value("t6_ot_pre", ot_cnt, 8'd0);
        cpl_done = 1'b1;
        tick();
        cpl_done = 1'b0;
        check_value("t6_err", err_cpl_underflow, 1'b1);
        check_value("t6_ot", ot_cnt, 8'd0);

        axi_bus.axi_axready = 1'b0;
        push(6'd9, 3'd2, 8'd1, 64'h5000);
        tick();
        check_value("t6_valid_held", axi_bus.axi_axvalid, 1'b1);
        push(6'd11, 3'd2, 8'd1, 64'h6000);
        axi_bus.axi_axready = 1'b1;
        reset = 1'b1;
        #1;
        check_value("t6_rst_no_pop", addrtrans_mem_rd, 1'b0);
        check_value("t6_rst_no_wr", rd_transfifo_wr, 1'b0);
        pops0 = pop_cnt;
        wrs0  = wr_cnt;
        tick();
        check_value("t6_rst_valid", axi_bus.axi_axvalid, 1'b0);
        check_value("t6_rst_fields", {axi_bus.axi_aid, axi_bus.axi_asize, axi_bus.axi_alen, axi_bus.axi_addr}, 81'h0);
        check_value("t6_rst_wrdata", io_transfifo_wrdata, 82'h0);
        check_value("t6_rst_ot", ot_cnt, 8'd0);
        check_value("t6_rst_err", err_cpl_underflow, 1'b0);
        check_value("t6_rst_pops", pop_cnt - pops0, 0);
        check_value("t6_rst_wrs", wr_cnt - wrs0, 0);
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
